// File: rtl/ps2_mouse_host_if.sv
// Decoded mouse state and controller status handed from the PS/2 host to the game logic.
interface ps2_mouse_host_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          pkt_valid;
    logic [2:0]    buttons;
    logic [8:0]    dx;
    logic [8:0]    dy;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic [2:0]    state;
    logic [3:0]    retries;

    modport master (output pkt_valid, buttons, dx, dy, cursor_x, cursor_y, state, retries);
    modport slave  (input  pkt_valid, buttons, dx, dy, cursor_x, cursor_y, state, retries);
endinterface

// File: rtl/ps2_mouse_host.sv
// PS/2 mouse host: start-up command handshake with retry, then 3-byte stream packets to cursor/buttons.
// state | meaning: IDLE after reset | INHIBIT clk held low | REQ data low | TX command | ACKB await FA | STREAM packets
module ps2_mouse_host #(
    parameter int         INHIBIT_CYCLES = 10000,
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter logic [7:0] CMD            = 8'hF4,
    parameter int         XW             = 10,
    parameter int         YW             = 10,
    parameter int         X_MAX          = 639,
    parameter int         Y_MAX          = 479
) (
    input  logic             clk,
    input  logic             clr,
    inout  wire              ps2_clk,
    inout  wire              ps2_data,
    ps2_mouse_host_if.master mif
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_INHIBIT = 3'd1, S_REQ = 3'd2,
        S_TX   = 3'd3, S_ACKB    = 3'd4, S_STREAM = 3'd5
    } state_t;

    localparam int MW = (XW > YW) ? XW : YW;
    localparam int CW = ((MW > 9) ? MW : 9) + 2;
    localparam logic signed [CW-1:0] P_XMAX = CW'(X_MAX);
    localparam logic signed [CW-1:0] P_YMAX = CW'(Y_MAX);
    localparam logic [7:0] P_CMD = CMD;

    state_t r_state, w_next;
    logic r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2;
    logic w_fe, w_chg, w_tmo, w_inh_done, w_fail;
    logic [31:0] r_tmr;
    logic [3:0]  r_bit;
    logic [8:0]  r_shift;
    logic        r_tx_val, w_tx_bit, w_tx_cur;
    logic        w_rx_on, w_rx_done, w_rx_good, w_rx_err;
    logic [7:0]  w_byte;
    logic [3:0]  r_retries;
    logic [1:0]  r_idx;
    logic [6:0]  r_b0;
    logic [7:0]  r_b1;
    logic        r_pkt;
    logic [2:0]  r_buttons;
    logic [8:0]  r_dx, r_dy, w_dx, w_dy;
    logic [XW-1:0] r_cur_x, w_x_new;
    logic [YW-1:0] r_cur_y, w_y_new;
    logic signed [CW-1:0] w_x_sum, w_y_sum;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            {r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2} <= 5'b11111;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fe       = r_clk_d & ~r_clk_s2;
    assign w_chg      = (w_next != r_state);
    assign w_tmo      = (r_tmr == 32'(TIMEOUT_CYCLES));
    assign w_inh_done = (r_tmr == 32'(INHIBIT_CYCLES - 1));

    // The host's own pull-down during INHIBIT shows up as an edge; it must not restart the inhibit timer.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                         r_tmr <= '0;
        else if (w_chg || (w_fe && r_state != S_INHIBIT)) r_tmr <= '0;
        else if (r_tmr != '1)                            r_tmr <= r_tmr + 32'd1;
    end

    assign w_tx_bit = (r_bit < 4'd8)  ? P_CMD[r_bit[2:0]] :
                      (r_bit == 4'd8) ? ~^P_CMD : 1'b1;
    assign w_tx_cur = (w_fe && r_state == S_TX) ? w_tx_bit : r_tx_val;

    assign ps2_clk  = (r_state == S_INHIBIT) ? 1'b0 : 1'bz;
    assign ps2_data = ((r_state == S_REQ) || (r_state == S_TX && !w_tx_cur)) ? 1'b0 : 1'bz;

    assign w_rx_on   = (r_state == S_ACKB) || (r_state == S_STREAM);
    assign w_rx_done = w_rx_on && w_fe && (r_bit == 4'd10);
    assign w_rx_good = w_rx_done && r_dat_s2 && (^r_shift);
    assign w_rx_err  = (w_rx_on && w_fe && r_bit == 4'd0 && r_dat_s2) || (w_rx_done && !w_rx_good);
    assign w_byte    = r_shift[7:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx_val <= 1'b1;
        end else begin
            if (r_state == S_REQ) r_tx_val <= 1'b0;
            else if (w_fe && r_state == S_TX) r_tx_val <= w_tx_bit;
            if (w_fe && w_rx_on && r_bit >= 4'd1 && r_bit <= 4'd9)
                r_shift <= {r_dat_s2, r_shift[8:1]};
            if (w_chg)
                r_bit <= '0;
            else if (r_state == S_STREAM && w_tmo && !w_fe)
                r_bit <= '0;
            else if (w_fe && (r_state == S_TX || w_rx_on)) begin
                if (r_bit == 4'd10 || (w_rx_on && r_bit == 4'd0 && r_dat_s2)) r_bit <= '0;
                else                                                         r_bit <= r_bit + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_fail = 1'b0;
        case (r_state)
            S_IDLE:    w_next = S_INHIBIT;
            S_INHIBIT: if (w_inh_done) w_next = S_REQ;
            S_REQ:     w_next = S_TX;
            S_TX: begin
                if (w_fe && r_bit == 4'd10) begin
                    if (!r_dat_s2) w_next = S_ACKB;
                    else           w_fail = 1'b1;
                end else if (w_tmo && !w_fe) begin
                    w_fail = 1'b1;
                end
            end
            S_ACKB: begin
                if (w_rx_good && w_byte == 8'hFA) w_next = S_STREAM;
                else if (w_rx_done || w_rx_err || (w_tmo && !w_fe)) w_fail = 1'b1;
            end
            S_STREAM:  w_next = S_STREAM;
            default:   w_next = S_IDLE;
        endcase
        if (w_fail) w_next = S_INHIBIT;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                              r_retries <= '0;
        else if (w_fail && r_retries != 4'hF) r_retries <= r_retries + 4'd1;
    end

    // r_b0 keeps {yovf, xovf, ysign, xsign, buttons}; the always-one bit 3 is not stored.
    assign w_dx = r_b0[5] ? 9'd0 : {r_b0[3], r_b1};
    assign w_dy = r_b0[6] ? 9'd0 : {r_b0[4], w_byte};

    always_comb begin
        w_x_sum = {{(CW-XW){1'b0}}, r_cur_x} + {{(CW-9){w_dx[8]}}, w_dx};
        w_y_sum = {{(CW-YW){1'b0}}, r_cur_y} - {{(CW-9){w_dy[8]}}, w_dy};
        if (w_x_sum[CW-1])        w_x_new = '0;
        else if (w_x_sum > P_XMAX) w_x_new = XW'(X_MAX);
        else                      w_x_new = w_x_sum[XW-1:0];
        if (w_y_sum[CW-1])        w_y_new = '0;
        else if (w_y_sum > P_YMAX) w_y_new = YW'(Y_MAX);
        else                      w_y_new = w_y_sum[YW-1:0];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_idx     <= '0;
            r_b0      <= '0;
            r_b1      <= '0;
            r_pkt     <= 1'b0;
            r_buttons <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_cur_x   <= XW'(X_MAX / 2);
            r_cur_y   <= YW'(Y_MAX / 2);
        end else begin
            r_pkt <= 1'b0;
            if (r_state == S_STREAM) begin
                if (w_rx_err || (w_tmo && !w_fe)) begin
                    r_idx <= '0;
                end else if (w_rx_good) begin
                    case (r_idx)
                        2'd0: if (w_byte[3]) begin
                            r_b0  <= {w_byte[7:4], w_byte[2:0]};
                            r_idx <= 2'd1;
                        end
                        2'd1: begin
                            r_b1  <= w_byte;
                            r_idx <= 2'd2;
                        end
                        default: begin
                            r_idx     <= 2'd0;
                            r_pkt     <= 1'b1;
                            r_buttons <= r_b0[2:0];
                            r_dx      <= w_dx;
                            r_dy      <= w_dy;
                            r_cur_x   <= w_x_new;
                            r_cur_y   <= w_y_new;
                        end
                    endcase
                end
            end
        end
    end

    assign mif.pkt_valid = r_pkt;
    assign mif.buttons   = r_buttons;
    assign mif.dx        = r_dx;
    assign mif.dy        = r_dy;
    assign mif.cursor_x  = r_cur_x;
    assign mif.cursor_y  = r_cur_y;
    assign mif.state     = r_state;
    assign mif.retries   = r_retries;
endmodule

// File: tb/tb_ps2_mouse_host.sv
// Directed bench for ps2_mouse_host: a device model on the open-drain lines, a packet vector table and corner-case sequences.
module tb_ps2_mouse_host;
    localparam int INH = 20;
    localparam int TMO = 300;
    localparam int H   = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    wire  ps2_clk, ps2_data;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_mouse_host_if #(.XW(10), .YW(10)) mif ();

    ps2_mouse_host #(
        .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CMD(8'hF4),
        .XW(10), .YW(10), .X_MAX(639), .Y_MAX(479)
    ) dut (
        .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .mif(mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int inh_cnt = 0;
    logic prev_pv = 1'b0;

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [2:0] btn;
        logic [8:0] dx, dy;
        int         x, y;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mif.pkt_valid === 1'b1) begin
            pulse_cnt++;
            chk("pkt_valid_width", {31'd0, prev_pv}, 32'd0);
        end
        prev_pv = mif.pkt_valid;
        if (mif.state == 3'd1 && ps2_clk === 1'b0) inh_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (ps2_clk === 1'b1 && ps2_data === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic dev_pulses(input int n);
        tick(6);
        for (int k = 0; k < n; k++) begin
            dev_clk_low = 1'b1; tick(H);
            dev_clk_low = 1'b0; tick(H);
        end
    endtask

    // Device clocks the host command in, sampling the data line just before each falling edge.
    task automatic host_rx(output logic [10:0] bits);
        tick(6);
        for (int k = 0; k < 11; k++) begin
            bits[k] = ps2_data;
            if (k == 10) begin
                dev_dat_low = 1'b1;
                tick(4);
            end
            dev_clk_low = 1'b1; tick(H);
            dev_clk_low = 1'b0; tick(H);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < 11; k++) begin
            dev_dat_low = ~f[k]; tick(H);
            dev_clk_low = 1'b1;  tick(H);
            dev_clk_low = 1'b0;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0); tick(H);
        send_byte(b1, 1'b0); tick(H);
        send_byte(b2, 1'b0); tick(H);
    endtask

    task automatic chk_pkt(input string tag, input int pc0, input logic [2:0] btn,
                           input logic [8:0] dx, input logic [8:0] dy, input int x, input int y);
        chk({tag, "_pulses"}, pulse_cnt, pc0 + 1);
        chk({tag, "_buttons"}, {29'd0, mif.buttons}, {29'd0, btn});
        chk({tag, "_dx"}, {23'd0, mif.dx}, {23'd0, dx});
        chk({tag, "_dy"}, {23'd0, mif.dy}, {23'd0, dy});
        chk({tag, "_cursor_x"}, {22'd0, mif.cursor_x}, x);
        chk({tag, "_cursor_y"}, {22'd0, mif.cursor_y}, y);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        bit ok;
        int pc0;
        int i_to;

        vecs[0]  = '{8'h08, 8'h05, 8'h03, 3'd0, 9'h005, 9'h003, 324, 236};
        vecs[1]  = '{8'h18, 8'h00, 8'h00, 3'd0, 9'h100, 9'h000,  68, 236};
        vecs[2]  = '{8'h18, 8'h00, 8'h00, 3'd0, 9'h100, 9'h000,   0, 236};
        vecs[3]  = '{8'h08, 8'h03, 8'hE2, 3'd0, 9'h003, 9'h0E2,   3,  10};
        vecs[4]  = '{8'h19, 8'hF6, 8'h00, 3'd1, 9'h1F6, 9'h000,   0,  10};
        vecs[5]  = '{8'h48, 8'h50, 8'h02, 3'd0, 9'h000, 9'h002,   0,   8};
        vecs[6]  = '{8'h0A, 8'hFF, 8'h00, 3'd2, 9'h0FF, 9'h000, 255,   8};
        vecs[7]  = '{8'h08, 8'hFF, 8'h00, 3'd0, 9'h0FF, 9'h000, 510,   8};
        vecs[8]  = '{8'h0C, 8'hFF, 8'h00, 3'd4, 9'h0FF, 9'h000, 639,   8};
        vecs[9]  = '{8'h28, 8'h00, 8'h00, 3'd0, 9'h000, 9'h100, 639, 264};
        vecs[10] = '{8'h28, 8'h00, 8'h00, 3'd0, 9'h000, 9'h100, 639, 479};
        vecs[11] = '{8'h8B, 8'h10, 8'h7F, 3'd3, 9'h010, 9'h000, 639, 479};

        clr = 1'b1;
        tick(3);
        chk("rst_state", {29'd0, mif.state}, 32'd0);
        chk("rst_pkt_valid", {31'd0, mif.pkt_valid}, 32'd0);
        chk("rst_buttons", {29'd0, mif.buttons}, 32'd0);
        chk("rst_dx", {23'd0, mif.dx}, 32'd0);
        chk("rst_dy", {23'd0, mif.dy}, 32'd0);
        chk("rst_retries", {28'd0, mif.retries}, 32'd0);
        chk("rst_cursor_x", {22'd0, mif.cursor_x}, 32'd319);
        chk("rst_cursor_y", {22'd0, mif.cursor_y}, 32'd239);
        chk("rst_ps2_clk", {31'd0, ps2_clk}, 32'd1);
        chk("rst_ps2_data", {31'd0, ps2_data}, 32'd1);
        clr = 1'b0;

        // First attempt: clean line-ACK, then the device rejects with FE.
        wait_req(ok);
        chk("req1_seen", {31'd0, ok}, 32'd1);
        host_rx(bits);
        chk("tx1_bits", {21'd0, bits}, 32'h5E8);
        tick(2);
        chk("tx1_state_ackb", {29'd0, mif.state}, 32'd4);
        chk("tx1_retries", {28'd0, mif.retries}, 32'd0);
        inh_cnt = 0;
        tick(H);
        send_byte(8'hFE, 1'b0);
        wait_req(ok);
        chk("req2_seen", {31'd0, ok}, 32'd1);
        chk("retry_inhibit_len", inh_cnt, INH);
        chk("retry_count", {28'd0, mif.retries}, 32'd1);

        // Second attempt is acknowledged with FA.
        host_rx(bits);
        chk("tx2_bits", {21'd0, bits}, 32'h5E8);
        tick(H);
        send_byte(8'hFA, 1'b0);
        tick(H);
        chk("stream_state", {29'd0, mif.state}, 32'd5);
        chk("stream_retries", {28'd0, mif.retries}, 32'd1);
        chk("stream_ps2_clk", {31'd0, ps2_clk}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            pc0 = pulse_cnt;
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
            chk_pkt($sformatf("vec%0d", i), pc0, vecs[i].btn, vecs[i].dx, vecs[i].dy, vecs[i].x, vecs[i].y);
        end

        // Corrupted byte 1 discards the packet; the following packet is decoded alone.
        pc0 = pulse_cnt;
        send_byte(8'h08, 1'b0); tick(H);
        send_byte(8'h20, 1'b1); tick(H);
        chk("badpar_no_pulse", pulse_cnt, pc0);
        send_pkt(8'h18, 8'hFE, 8'h05);
        chk_pkt("badpar", pc0, 3'd0, 9'h1FE, 9'h005, 637, 474);

        // A first byte without bit 3 is dropped.
        pc0 = pulse_cnt;
        send_byte(8'h05, 1'b0); tick(H);
        send_pkt(8'h08, 8'h01, 8'h01);
        chk_pkt("resync", pc0, 3'd0, 9'h001, 9'h001, 638, 473);

        // A long gap between packet bytes restarts assembly at byte 0.
        pc0 = pulse_cnt;
        send_byte(8'h08, 1'b0); tick(H);
        send_byte(8'h03, 1'b0);
        tick(TMO + 50);
        chk("gap_no_pulse", pulse_cnt, pc0);
        send_pkt(8'h08, 8'h04, 8'h02);
        chk_pkt("gap", pc0, 3'd0, 9'h004, 9'h002, 639, 471);

        // Device stalls mid-TX.
        clr = 1'b1; tick(2); clr = 1'b0;
        wait_req(ok);
        chk("req3_seen", {31'd0, ok}, 32'd1);
        dev_pulses(3);
        i_to = 0;
        ok = 1'b0;
        for (int i = 0; i < TMO + 100 && !ok; i++) begin
            @(negedge clk);
            i_to = i;
            if (mif.state == 3'd1) ok = 1'b1;
        end
        chk("tmo_state_inhibit", {29'd0, mif.state}, 32'd1);
        chk("tmo_not_early", {31'd0, (i_to >= TMO / 2)}, 32'd1);
        chk("tmo_retries", {28'd0, mif.retries}, 32'd1);
        chk("tmo_ps2_clk_low", {31'd0, ps2_clk}, 32'd0);

        // Reset asserted mid-transfer releases the lines without waiting for a clock edge.
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (mif.state == 3'd3) ok = 1'b1;
        end
        chk("clr_in_tx", {29'd0, mif.state}, 32'd3);
        chk("clr_tx_data_low", {31'd0, ps2_data}, 32'd0);
        #2;
        clr = 1'b1;
        #1;
        chk("clr_ps2_clk", {31'd0, ps2_clk}, 32'd1);
        chk("clr_ps2_data", {31'd0, ps2_data}, 32'd1);
        chk("clr_state", {29'd0, mif.state}, 32'd0);
        tick(2);
        clr = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_host.md
# ps2_mouse_host

Parametrised PS/2 mouse host controller that owns the bidirectional PS/2 clock/data lines. It performs the host-to-device command handshake with ACK checking, automatic retry and timeouts, then assembles 3-byte stream packets into decoded button and delta outputs. It also maintains a clamped on-screen cursor position. It sits between the board PS/2 pins and the game logic that consumes cursor and button state.

## Interface
- `INHIBIT_CYCLES`, default 10000: clk cycles the host holds `ps2_clk` low before a request (100 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum clk cycles allowed between device clock falling edges while a transfer is in progress (20 ms).
- `CMD`, default 8'hF4: command byte sent at start-up (Enable Data Reporting).
- `XW`, default 10: cursor X width.
- `YW`, default 10: cursor Y width.
- `X_MAX`, default 639: highest cursor X value.
- `Y_MAX`, default 479: highest cursor Y value.

Ports:
- `clk` in 1: system clock; the single clock domain.
- `clr` in 1: reset, asynchronous, active-high.
- `ps2_clk` inout 1: open-drain; the host only ever drives 0 or Z.
- `ps2_data` inout 1: open-drain; the host only ever drives 0 or Z.
- `pkt_valid` out 1: one-cycle pulse when a packet is accepted.
- `buttons` out 3: {middle, right, left}.
- `dx` out 9: signed X delta of the last packet.
- `dy` out 9: signed Y delta of the last packet.
- `cursor_x` out XW: clamped X position.
- `cursor_y` out YW: clamped Y position.
- `state` out 3: FSM state encoding.
- `retries` out 4: saturating count of failed command attempts.

## Operation
- Input conditioning:
  - `ps2_clk` and `ps2_data` pass through 2-FF synchronisers.
  - A falling edge ("fe") is sync'd clk going from 1 to 0, as seen by an edge register.
- States:
  - IDLE=0: entered after reset. Moves to INHIBIT on the next cycle.
  - INHIBIT=1: drive `ps2_clk` low for INHIBIT_CYCLES, then go to REQ.
  - REQ=2: drive `ps2_data` low and release `ps2_clk` in the same cycle, then go to TX.
  - TX=3: on each fe, present the next bit: CMD[0..7] LSB first, then odd parity, then stop (data released, Z). On the fe after the stop bit, sample the line-ACK. Line-ACK=0 goes to ACKB; line-ACK=1 is a failure.
  - ACKB=4: receive one device frame. A byte of 8'hFA goes to STREAM; any other byte, or a frame error, is a failure.
  - STREAM=5: receive frames indefinitely.
- Failure handling (line-ACK high, wrong ACK byte, frame error in ACKB, or timeout in REQ/TX/ACKB):
  - `retries` += 1, saturating at 15.
  - Release both lines and return to INHIBIT.
- Device frame: start bit = 0, 8 data bits LSB first, odd parity, stop bit = 1. A bad start, parity or stop bit is a frame error.
- STREAM packet assembly uses a byte index 0..2:
  - A frame error, or a gap of more than TIMEOUT_CYCLES between fe's inside a frame, discards the frame and resets the index to 0.
  - If a gap exceeds TIMEOUT_CYCLES between packet bytes, the index is reset to 0.
  - Byte 0 is accepted only if bit3=1; otherwise it is dropped (resync).
  - After byte 2 is accepted:
    - `buttons`=b0[2:0].
    - `dx`={b0[4],b1}, `dy`={b0[5],b2}.
    - If b0[6] (X overflow) is set, `dx`=0; if b0[7] (Y overflow) is set, `dy`=0.
- Cursor update: `cursor_x`=clamp(x+dx, 0, X_MAX) and `cursor_y`=clamp(y−dy, 0, Y_MAX), since PS/2 +Y means up.
  - Compute with at least max(XW,YW)+2 signed bits; there is no wrap-around.
- The host never drives either line in STREAM.

## Timing
- Reset values:
  - `state`=0, `pkt_valid`=0, `buttons`=0, `dx`=`dy`=0, `retries`=0.
  - `cursor_x`=X_MAX/2, `cursor_y`=Y_MAX/2 (integer division).
  - Both lines released (Z).
- Reset asserted mid-transfer releases both lines immediately (asynchronously) and restarts from IDLE.
- Latency from a pin edge to fe is 3 clk cycles.
- If the byte-2 stop bit is sampled on fe at cycle N:
  - `pkt_valid`, `buttons`, `dx`, `dy`, `cursor_x` and `cursor_y` all update at N+1.
  - `pkt_valid` is high for exactly that one cycle.
- Outputs hold their values between packets.
- The timeout counter clears on every fe and on every state change. Timeout fires when the count reaches TIMEOUT_CYCLES.
- The data bit in TX changes on the same cycle the fe is detected.

## Test plan
- Device model clocks the command in and answers with line-ACK=0 then 8'hFA -> bit sequence received is 0,F4 LSB-first,parity 0,stop 1; `state` reaches 5; `retries`=0.
- Device answers the first attempt with 8'hFE, the second with 8'hFA -> `retries`=1; `ps2_clk` is held low again for INHIBIT_CYCLES; final `state`=5.
- Packet 08,05,03 from reset (cursor at 319,239) -> one `pkt_valid` pulse; `dx`=5, `dy`=3, cursor=(324,236).
- Packet 19,F6,00 with cursor at (3,10) -> `dx`=−10; `cursor_x` clamps to 0; `buttons`=3'b001.
- Bad parity on byte 1, followed by a full valid packet -> no pulse for the corrupted packet; exactly one pulse with the valid packet's values.
- Device stops clocking mid-TX for more than TIMEOUT_CYCLES -> `retries` increments and the FSM returns to INHIBIT. Separately, `clr` pulsed while in TX -> both lines released within the same cycle and `state`=0.
